seq_alu: RTL and testbench

Parametrised, registered ALU with a start/done handshake, WIDTH-bit signed operands and iterative (multi-cycle) multiply and divide. It replaces the single-cycle combinational ALU in the execute stage: the control unit issues an operation with In_Start, stalls on Out_Busy and reads Out_Result/Out_Zero when Out_Done pulses. The opcode encoding is unchanged from the current 4-bit ALU control, so existing decode logic drives it directly.

---
 rtl/seq_alu.sv | 219 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered signed ALU with a start/done handshake and iterative
// multi-cycle multiply (shift-add) and divide (restoring).
// Optional feature macro: SEQ_ALU_DIV_EN builds the divider datapath and its
// states; without it, opcode DIV completes in one cycle with a zero result.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             In_Clk,
    input  logic             In_Reset_n,
    input  logic             In_Start,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic [3:0]       In_ALUCtrl,
    output logic [WIDTH-1:0] Out_Result,
    output logic             Out_Zero,
    output logic             Out_DivZero,
    output logic             Out_Busy,
    output logic             Out_Done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_DEC  = 4'b1011;
    localparam logic [3:0] OP_SLA  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_PASS = 4'b1110;
    localparam logic [3:0] OP_ZERO = 4'b1111;

`ifdef SEQ_ALU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX} state_t;
`else
    typedef enum logic [0:0] {IDLE, MUL_RUN} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             divZero_q;
    logic             busy_q;
    logic             done_q;
    logic             negate_q;
    logic [WIDTH-1:0] mulAcc_q;
    logic [WIDTH-1:0] mulCand_q;
    logic [WIDTH-1:0] mulPlier_q;

    logic [WIDTH-1:0] aluResult_d;
    logic [WIDTH-1:0] aMag_d;
    logic [WIDTH-1:0] bMag_d;
    logic [WIDTH-1:0] mulSum_d;
    logic [WIDTH-1:0] mulFinal_d;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] divRem_q;
    logic [WIDTH-1:0] divQuo_q;
    logic [WIDTH-1:0] divSor_q;
    logic             divByZero_q;

    logic [WIDTH:0]   divShift_d;
    logic [WIDTH:0]   divTrial_d;
    logic             divFits_d;
    logic [WIDTH-1:0] divFinal_d;
`endif

    assign Out_Result  = result_q;
    assign Out_Zero    = zero_q;
    assign Out_DivZero = divZero_q;
    assign Out_Busy    = busy_q;
    assign Out_Done    = done_q;

    // Single-cycle operations and operand magnitudes for the iterative units
    always_comb begin
        aluResult_d = '0;
        aMag_d      = In_A[WIDTH-1] ? -In_A : In_A;
        bMag_d      = In_B[WIDTH-1] ? -In_B : In_B;
        case (In_ALUCtrl)
            OP_ADD:          aluResult_d = In_A + In_B;
            OP_SUB:          aluResult_d = In_A - In_B;
            OP_AND:          aluResult_d = In_A & In_B;
            OP_OR:           aluResult_d = In_A | In_B;
            OP_XOR:          aluResult_d = In_A ^ In_B;
            OP_SLL, OP_SLA:  aluResult_d = In_A << In_B;
            OP_SRL:          aluResult_d = In_A >> In_B;
            OP_NOT:          aluResult_d = ~In_A;
            OP_INC:          aluResult_d = In_A + WIDTH'(1);
            OP_DEC:          aluResult_d = In_A - WIDTH'(1);
            OP_SRA:          aluResult_d = $signed(In_A) >>> In_B;
            OP_PASS:         aluResult_d = In_B;
            OP_MUL, OP_DIV,
            OP_ZERO:         aluResult_d = '0;
            default:         aluResult_d = '0;
        endcase
    end

    // One shift-add step and the signed result of the final step
    always_comb begin
        mulSum_d   = mulAcc_q + (mulPlier_q[0] ? mulCand_q : '0);
        mulFinal_d = negate_q ? -mulSum_d : mulSum_d;
    end

`ifdef SEQ_ALU_DIV_EN
    // One restoring-divide step and the sign/zero-divisor fixup value
    always_comb begin
        divShift_d = {divRem_q, divQuo_q[WIDTH-1]};
        divTrial_d = divShift_d - {1'b0, divSor_q};
        divFits_d  = ~divTrial_d[WIDTH];
        divFinal_d = divByZero_q ? '1 : (negate_q ? -divQuo_q : divQuo_q);
    end
`endif

    // Control FSM, iterative datapath registers and registered outputs
    always_ff @(posedge In_Clk) begin
        if (!In_Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            divZero_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            negate_q   <= 1'b0;
            mulAcc_q   <= '0;
            mulCand_q  <= '0;
            mulPlier_q <= '0;
`ifdef SEQ_ALU_DIV_EN
            divRem_q    <= '0;
            divQuo_q    <= '0;
            divSor_q    <= '0;
            divByZero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (In_Start) begin
                        if (In_ALUCtrl == OP_MUL) begin
                            state_q    <= MUL_RUN;
                            busy_q     <= 1'b1;
                            cnt_q      <= '0;
                            negate_q   <= In_A[WIDTH-1] ^ In_B[WIDTH-1];
                            mulAcc_q   <= '0;
                            mulCand_q  <= aMag_d;
                            mulPlier_q <= bMag_d;
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (In_ALUCtrl == OP_DIV) begin
                            state_q     <= DIV_RUN;
                            busy_q      <= 1'b1;
                            cnt_q       <= '0;
                            negate_q    <= In_A[WIDTH-1] ^ In_B[WIDTH-1];
                            divRem_q    <= '0;
                            divQuo_q    <= aMag_d;
                            divSor_q    <= bMag_d;
                            divByZero_q <= (In_B == '0);
                        end
`endif
                        else begin
                            result_q  <= aluResult_d;
                            zero_q    <= (aluResult_d == '0);
                            divZero_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    mulAcc_q   <= mulSum_d;
                    mulCand_q  <= mulCand_q << 1;
                    mulPlier_q <= mulPlier_q >> 1;
                    cnt_q      <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        result_q  <= mulFinal_d;
                        zero_q    <= (mulFinal_d == '0);
                        divZero_q <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV_RUN: begin
                    divRem_q <= divFits_d ? divTrial_d[WIDTH-1:0] : divShift_d[WIDTH-1:0];
                    divQuo_q <= {divQuo_q[WIDTH-2:0], divFits_d};
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= DIV_FIX;
                        cnt_q   <= '0;
                    end
                end
                DIV_FIX: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    result_q  <= divFinal_d;
                    zero_q    <= (divFinal_d == '0);
                    divZero_q <= divByZero_q;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed stimulus for seq_alu with a cycle-level reference model
// (plain integer arithmetic plus a latency countdown) compared every cycle,
// and literal expectations for the hand-computed vectors.
// Honours SEQ_ALU_DIV_EN the same way the design does.
module tb_seq_alu;

    localparam int W = 16;

    logic         In_Clk = 1'b0;
    logic         In_Reset_n = 1'b0;
    logic         In_Start = 1'b0;
    logic [W-1:0] In_A = '0;
    logic [W-1:0] In_B = '0;
    logic [3:0]   In_ALUCtrl = '0;
    logic [W-1:0] Out_Result;
    logic         Out_Zero;
    logic         Out_DivZero;
    logic         Out_Busy;
    logic         Out_Done;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs must be in the current cycle
    logic [W-1:0] expResult = '0;
    logic         expZero = 1'b1;
    logic         expDivZero = 1'b0;
    logic         expBusy = 1'b0;
    logic         expDone = 1'b0;
    logic         modelValid = 1'b0;
    int           mRemain = 0;
    logic [W-1:0] mPend = '0;
    logic         mPendDz = 1'b0;

    seq_alu #(.WIDTH(W)) dut (
        .In_Clk      (In_Clk),
        .In_Reset_n  (In_Reset_n),
        .In_Start    (In_Start),
        .In_A        (In_A),
        .In_B        (In_B),
        .In_ALUCtrl  (In_ALUCtrl),
        .Out_Result  (Out_Result),
        .Out_Zero    (Out_Zero),
        .Out_DivZero (Out_DivZero),
        .Out_Busy    (Out_Busy),
        .Out_Done    (Out_Done)
    );

    // Free-running clock
    always #5 In_Clk = ~In_Clk;

    // Arithmetic meaning of each opcode, computed on wide signed integers
    function automatic logic [W-1:0] refResult(input logic [3:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = 0;
        case (op)
            4'd0:        r = sa + sb;
            4'd1:        r = sa - sb;
            4'd2:        r = ua & ub;
            4'd3:        r = ua | ub;
            4'd4:        r = ua ^ ub;
            4'd5, 4'd12: r = (ub >= W) ? 0 : (sa <<< ub);
            4'd6:        r = (ub >= W) ? 0 : (ua >> ub);
            4'd7:        r = ~ua;
            4'd8:        r = sa * sb;
`ifdef SEQ_ALU_DIV_EN
            4'd9:        r = (sb == 0) ? -1 : (sa / sb);
`else
            4'd9:        r = 0;
`endif
            4'd10:       r = sa + 1;
            4'd11:       r = sa - 1;
            4'd13:       r = (ub >= W) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
            4'd14:       r = sb;
            default:     r = 0;
        endcase
        return r[W-1:0];
    endfunction

    function automatic logic refDivZero(input logic [3:0] op, input logic [W-1:0] b);
`ifdef SEQ_ALU_DIV_EN
        return (op == 4'd9) && (b == '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int refLatency(input logic [3:0] op);
        if (op == 4'd8) return W + 1;
`ifdef SEQ_ALU_DIV_EN
        if (op == 4'd9) return W + 2;
`endif
        return 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model advances on every rising edge from the sampled inputs
    always @(posedge In_Clk) begin
        if (!In_Reset_n) begin
            modelValid <= 1'b1;
            expResult  <= '0;
            expZero    <= 1'b1;
            expDivZero <= 1'b0;
            expBusy    <= 1'b0;
            expDone    <= 1'b0;
            mRemain    <= 0;
        end else if (mRemain > 0) begin
            mRemain <= mRemain - 1;
            if (mRemain == 1) begin
                expBusy    <= 1'b0;
                expDone    <= 1'b1;
                expResult  <= mPend;
                expZero    <= (mPend == '0);
                expDivZero <= mPendDz;
            end else begin
                expDone <= 1'b0;
            end
        end else if (In_Start) begin
            if (refLatency(In_ALUCtrl) == 1) begin
                expDone    <= 1'b1;
                expResult  <= refResult(In_ALUCtrl, In_A, In_B);
                expZero    <= (refResult(In_ALUCtrl, In_A, In_B) == '0);
                expDivZero <= refDivZero(In_ALUCtrl, In_B);
            end else begin
                mRemain <= refLatency(In_ALUCtrl) - 1;
                expBusy <= 1'b1;
                expDone <= 1'b0;
                mPend   <= refResult(In_ALUCtrl, In_A, In_B);
                mPendDz <= refDivZero(In_ALUCtrl, In_B);
            end
        end else begin
            expDone <= 1'b0;
        end
    end

    // Every cycle, compare all DUT outputs against the model on the falling edge
    always @(negedge In_Clk) begin
        if (modelValid) begin
            checkOutput("cyc_busy", Out_Busy, expBusy);
            checkOutput("cyc_done", Out_Done, expDone);
            checkOutput("cyc_result", Out_Result, expResult);
            checkOutput("cyc_zero", Out_Zero, expZero);
            checkOutput("cyc_divzero", Out_DivZero, expDivZero);
        end
    end

    // Present one request for exactly one edge; returns 1 time unit after it
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        In_ALUCtrl = op;
        In_A       = a;
        In_B       = b;
        In_Start   = 1'b1;
        @(posedge In_Clk);
        #1;
        In_Start = 1'b0;
    endtask

    // Count cycles until Out_Done (bounded); optionally poke In_Start while busy
    task automatic waitDone(output int lat, input bit pokeBusy);
        lat = 1;
        while (!Out_Done && lat < 40) begin
            if (pokeBusy && (lat == 4 || lat == 9)) begin
                In_Start   = 1'b1;
                In_ALUCtrl = 4'd0;
                In_A       = 16'h1111;
                In_B       = 16'h2222;
            end else begin
                In_Start = 1'b0;
            end
            @(posedge In_Clk);
            #1;
            lat++;
        end
        In_Start = 1'b0;
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int  lat;
        bit  doneSeen;

        // Reset held two cycles while a request is presented
        In_Reset_n = 1'b0;
        In_Start   = 1'b1;
        In_ALUCtrl = 4'd0;
        In_A       = 16'd1;
        In_B       = 16'd2;
        repeat (2) @(posedge In_Clk);
        #1;
        checkOutput("rst_result", Out_Result, 16'h0000);
        checkOutput("rst_zero", Out_Zero, 1'b1);
        checkOutput("rst_busy", Out_Busy, 1'b0);
        checkOutput("rst_done", Out_Done, 1'b0);
        checkOutput("rst_divzero", Out_DivZero, 1'b0);
        In_Start   = 1'b0;
        In_Reset_n = 1'b1;
        @(posedge In_Clk);
        #1;

        // Back-to-back single-cycle operations
        applyStimulus(4'd0, 16'h7FFF, 16'h0001);
        checkOutput("add_done", Out_Done, 1'b1);
        checkOutput("add_result", Out_Result, 16'h8000);
        applyStimulus(4'd1, 16'd5, 16'd5);
        checkOutput("sub_done", Out_Done, 1'b1);
        checkOutput("sub_result", Out_Result, 16'h0000);
        checkOutput("sub_zero", Out_Zero, 1'b1);
        applyStimulus(4'd13, 16'h8000, 16'd3);
        checkOutput("sra_result", Out_Result, 16'hF000);
        applyStimulus(4'd6, 16'h8000, 16'd20);
        checkOutput("srl_big_result", Out_Result, 16'h0000);
        applyStimulus(4'd14, 16'h0001, 16'hBEEF);
        checkOutput("pass_result", Out_Result, 16'hBEEF);
        checkOutput("pass_zero", Out_Zero, 1'b0);
        applyStimulus(4'd15, 16'h1234, 16'h5678);
        checkOutput("op15_result", Out_Result, 16'h0000);
        checkOutput("op15_done", Out_Done, 1'b1);
        applyStimulus(4'd13, 16'h8000, 16'd16);
        checkOutput("sra_big_result", Out_Result, 16'hFFFF);
        applyStimulus(4'd5, 16'h0003, 16'd4);
        checkOutput("sll_result", Out_Result, 16'h0030);

        // Multiply, with ignored requests while busy
        applyStimulus(4'd8, 16'hFFFD, 16'd7);
        checkOutput("mul_busy", Out_Busy, 1'b1);
        waitDone(lat, 1'b1);
        checkOutput("mul_latency", lat, W + 1);
        checkOutput("mul_result", Out_Result, 16'hFFEB);
        applyStimulus(4'd8, 16'h0100, 16'h0100);
        waitDone(lat, 1'b0);
        checkOutput("mul_wrap_result", Out_Result, 16'h0000);
        checkOutput("mul_wrap_zero", Out_Zero, 1'b1);
        applyStimulus(4'd8, 16'h8000, 16'hFFFF);
        waitDone(lat, 1'b0);
        checkOutput("mul_min_result", Out_Result, 16'h8000);

        // MUL then ADD issued in the MUL's Out_Done cycle
        applyStimulus(4'd8, 16'd3, 16'd4);
        waitDone(lat, 1'b0);
        checkOutput("b2b_mul_result", Out_Result, 16'd12);
        checkOutput("b2b_mul_busy", Out_Busy, 1'b0);
        applyStimulus(4'd0, 16'd10, 16'd20);
        checkOutput("b2b_add_done", Out_Done, 1'b1);
        checkOutput("b2b_add_result", Out_Result, 16'd30);

`ifdef SEQ_ALU_DIV_EN
        applyStimulus(4'd9, 16'hFFF9, 16'd2);
        waitDone(lat, 1'b1);
        checkOutput("div_latency", lat, W + 2);
        checkOutput("div_result", Out_Result, 16'hFFFD);
        checkOutput("div_dz", Out_DivZero, 1'b0);
        applyStimulus(4'd9, 16'h8000, 16'hFFFF);
        waitDone(lat, 1'b0);
        checkOutput("div_min_result", Out_Result, 16'h8000);
        checkOutput("div_min_dz", Out_DivZero, 1'b0);
        applyStimulus(4'd9, 16'd9, 16'd0);
        waitDone(lat, 1'b0);
        checkOutput("div0_latency", lat, W + 2);
        checkOutput("div0_result", Out_Result, 16'hFFFF);
        checkOutput("div0_dz", Out_DivZero, 1'b1);
        applyStimulus(4'd0, 16'd1, 16'd1);
        checkOutput("div0_clear_result", Out_Result, 16'd2);
        checkOutput("div0_clear_dz", Out_DivZero, 1'b0);
`else
        applyStimulus(4'd9, 16'd9, 16'd3);
        checkOutput("nodiv_done", Out_Done, 1'b1);
        checkOutput("nodiv_result", Out_Result, 16'h0000);
        checkOutput("nodiv_zero", Out_Zero, 1'b1);
        checkOutput("nodiv_dz", Out_DivZero, 1'b0);
`endif

        // Abort a long operation with reset in its fifth busy cycle
`ifdef SEQ_ALU_DIV_EN
        applyStimulus(4'd9, 16'd100, 16'd7);
`else
        applyStimulus(4'd8, 16'd100, 16'd7);
`endif
        repeat (4) begin
            @(posedge In_Clk);
            #1;
        end
        In_Reset_n = 1'b0;
        @(posedge In_Clk);
        #1;
        In_Reset_n = 1'b1;
        checkOutput("abort_busy", Out_Busy, 1'b0);
        checkOutput("abort_done", Out_Done, 1'b0);
        checkOutput("abort_result", Out_Result, 16'h0000);
        doneSeen = 1'b0;
        repeat (25) begin
            @(posedge In_Clk);
            #1;
            if (Out_Done) doneSeen = 1'b1;
        end
        checkOutput("abort_no_done", doneSeen, 1'b0);

        // Recovery after abort
        applyStimulus(4'd0, 16'd2, 16'd3);
        checkOutput("recover_result", Out_Result, 16'd5);
        @(posedge In_Clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
